// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   size_e  : access size encodings carried on the size input
//   state_e : handshake FSM states
//   DefaultLatency / DefaultDepthBytes : parameter defaults for mem_responder
//   is_bad_access() : alignment / reserved-size rejection check
package mem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned DefaultLatency    = 2;
  localparam int unsigned DefaultDepthBytes = 512;

  // A request is rejected when it is misaligned for its size or uses the reserved size.
  function automatic logic is_bad_access(size_e sz, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      SizeByte: bad = 1'b0;
      SizeHalf: bad = off[0];
      SizeWord: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Byte-lane word storage.
//   clk     : clock
//   we      : per-lane write enable, bit 3 = bits [31:24] (lowest byte address, big-endian)
//   waddr   : word index for writes
//   wdata   : write data, lanes selected by we
//   raddr   : word index for reads
//   rdata   : registered read data, valid the cycle after raddr is presented
// Contents have no reset; they survive a responder reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DefaultDepthBytes,
  localparam int unsigned WordAw     = $clog2(DEPTH_BYTES) - 2,
  localparam int unsigned NumWords   = DEPTH_BYTES / 4
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [WordAw-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [WordAw-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [NumWords];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder speaking a 4-phase mov/moc handshake.
//   clk      : clock
//   reset    : synchronous active-low reset
//   mov      : request (held until moc, then dropped)
//   rw       : 1 = read, 0 = write
//   addr     : byte address, only the low log2(DEPTH_BYTES) bits are used
//   size     : 00 byte, 01 halfword, 10 word, 11 reserved
//   data_in  : right-justified write data
//   data_out : right-justified, zero-extended read data
//   moc      : acknowledge, raised LATENCY cycles after the capture edge
//   err      : qualifies moc, 1 = request rejected
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY     = DefaultLatency,
  parameter int unsigned DEPTH_BYTES = DefaultDepthBytes
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);

  localparam int unsigned Aw      = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [Aw-1:0] addr_q, addr_d;
  size_e         size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          moc_q, moc_d;
  logic          err_q, err_d;

  logic          bad;
  logic          fire;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [31:0]   rd_val;
  logic [31:0]   rd_shift;
  logic [3:0]    mem_we;
  logic [Aw-3:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          unused_addr;

  assign unused_addr = ^addr[31:Aw];

  assign bad  = is_bad_access(size_q, addr_q[1:0]);
  // The access happens on the edge that leaves WAIT.
  assign fire = (state_q == StWait) && (cnt_q == 4'd0);

  // Big-endian lane steering: byte offset 0 sits in bits [31:24].
  assign rd_shift = mem_rdata >> {~addr_q[1:0], 3'b000};

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    rd_val  = 32'h0;
    unique case (size_q)
      SizeByte: begin
        wr_be   = 4'b1000 >> addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
        rd_val  = {24'h0, rd_shift[7:0]};
      end
      SizeHalf: begin
        wr_be   = addr_q[1] ? 4'b0011 : 4'b1100;
        wr_data = {2{wdata_q[15:0]}};
        rd_val  = {16'h0, (addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16])};
      end
      SizeWord: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
        rd_val  = mem_rdata;
      end
      SizeRsvd: begin
        wr_be   = 4'b0000;
      end
    endcase
  end

  // Reset gates the write so an aborted access never commits.
  assign mem_we = (fire && !rw_q && !bad && reset) ? wr_be : 4'b0000;

  // In IDLE the array is pointed at the incoming address so the word is ready even for
  // LATENCY=1; afterwards it tracks the captured address.
  assign mem_raddr = (state_q == StIdle) ? addr[Aw-1:2] : addr_q[Aw-1:2];

  mem_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q[Aw-1:2]),
    .wdata(wr_data),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    moc_d      = moc_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (mov) begin
          rw_d    = rw;
          addr_d  = addr[Aw-1:0];
          size_d  = size_e'(size);
          wdata_d = data_in;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          moc_d   = 1'b1;
          err_d   = bad;
          if (rw_q && !bad) begin
            data_out_d = rd_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // Leaving only on mov low means a held mov cannot start a second access.
        if (!mov) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= SizeByte;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
      moc_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      moc_q      <= moc_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign moc      = moc_q;
  assign err      = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from accepted request to moc rising; legal range 1..15.
REQ-002 Parameter DEPTH_BYTES, default 512, byte capacity; power of two.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 mov  in  1  memory operation valid, driven by control unit; 4-phase handshake request.
REQ-006 rw  in  1  1 = read, 0 = write.
REQ-007 addr  in  32  byte address; only bits [log2(DEPTH_BYTES)-1:0] used, upper bits ignored.
REQ-008 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 data_in  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-010 data_out  out  32  read data, right-justified, zero-extended.
REQ-011 moc  out  1  memory operation complete; 4-phase handshake acknowledge.
REQ-012 err  out  1  qualifies moc; 1 = request rejected.

Function
REQ-013 FSM states: IDLE, WAIT, DONE.
REQ-014 IDLE: on posedge with mov=1, capture rw, addr, size, data_in into request registers; load counter with LATENCY-1; go to WAIT.
REQ-015 Inputs other than mov are ignored outside the capture edge.
REQ-016 WAIT: counter decrements each cycle; on the edge where counter is 0, perform access, go to DONE; moc rises exactly LATENCY cycles after the capture edge.
REQ-017 DONE: moc=1 held until mov=0 is sampled; on that edge moc=0, err=0, go to IDLE.
REQ-018 New request accepted only in IDLE; mov held high across DONE->IDLE does not start a second access (mov must be seen low first).
REQ-019 Storage is big-endian: byte at addr holds bits [31:24] of the word at addr&~3.
REQ-020 Write: byte/halfword updates only addressed lanes; other bytes unchanged; commit occurs on the edge entering DONE.
REQ-021 Read: data_out loaded on the edge entering DONE, zero-extended; sign extension is the datapath's responsibility; data_out held otherwise.
REQ-022 Misalignment (halfword addr[0]=1, word addr[1:0]!=0) or size=11: no memory change, data_out unchanged, moc with err=1, same latency.
REQ-023 Write then read of same address in back-to-back handshakes returns the new data.

Reset
REQ-024 reset=0 at posedge: state IDLE, counter 0, moc=0, err=0, data_out=0, request registers 0.
REQ-025 Reset during WAIT aborts the access: no write commits; memory contents are not cleared by reset.
REQ-026 Reset takes priority over every other event on the same edge.

Structure
REQ-027 Shared package mem_pkg holds: size encodings, FSM state enum, LATENCY and DEPTH_BYTES defaults.
REQ-028 One sub-module, mem_array: byte-lane storage with 4-bit write-enable and a 32-bit synchronous read port; mem_responder owns FSM, counter, alignment check and lane steering.
REQ-029 Target size 150-300 lines RTL total.

Verification
REQ-030 Word write 0xDEADBEEF @0x10, then word read @0x10 -> data_out=0xDEADBEEF, err=0, moc high 2 cycles after each capture edge.
REQ-031 Byte write 0xAA @0x13 over word 0x11223344 @0x10, then word read -> 0x112233AA; byte read @0x10 -> 0x00000011.
REQ-032 Halfword read @0x11 -> moc=1, err=1, memory and data_out unchanged.
REQ-033 mov held high 5 cycles after moc -> moc stays high, no second access; mov low -> moc low next edge, next mov accepted.
REQ-034 Word write @0x20 with reset=0 one cycle after capture -> moc never rises; subsequent read @0x20 returns prior contents.
REQ-035 addr=0xFFFF_FE04 with DEPTH_BYTES=512 -> aliases to 0x004 for read and write.
